// File: rtl/whack_pkg.sv
// Shared types, LFSR constants and helpers for the whack grid game controller.
package whack_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_WARN  = 2'd1,
        CELL_FIRE  = 2'd2,
        CELL_GOLD  = 2'd3
    } cell_state_t;

    localparam int unsigned LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask on bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned POP_W = 5;

    function automatic logic [POP_W-1:0] popcount16(input logic [15:0] v);
        logic [POP_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + POP_W'(v[i]);
        end
        return sum;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/whack_grid_controller_cell.sv
// Single grid cell: EMPTY/WARN/FIRE/GOLD state with a tick-driven down-counter.
module whack_cell
    import whack_pkg::*;
#(
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned WARN_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             spawn,
    input  logic             spawn_kind,
    input  logic             hit,
    input  logic [CNT_W-1:0] active_load,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             gold_hit,
    output logic             fire_hit
);

    cell_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lit;

    assign lit      = (state_q == CELL_FIRE) || (state_q == CELL_GOLD);
    assign gold_hit = hit && (state_q == CELL_GOLD);
    assign fire_hit = hit && (state_q == CELL_FIRE);
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CELL_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A hit on a lit cell wins over any tick-driven expiry or transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear || (hit && lit)) begin
            state_d = CELL_EMPTY;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                CELL_EMPTY: begin
                    if (spawn) begin
                        if (spawn_kind) begin
                            state_d = CELL_WARN;
                            cnt_d   = CNT_W'(WARN_TICKS);
                        end else begin
                            state_d = CELL_GOLD;
                            cnt_d   = active_load;
                        end
                    end
                end
                CELL_WARN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = CELL_FIRE;
                        cnt_d   = active_load;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                CELL_FIRE, CELL_GOLD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = CELL_EMPTY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = CELL_EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/whack_grid_controller.sv
// Whack grid game controller: game FSM, LFSR spawner, hit scoring over NUM_BOXES cells.
// Optional DIFFICULTY_RAMP_EN shortens FIRE/GOLD lifetime as the score grows.
module whack_grid_controller
    import whack_pkg::*;
#(
    parameter int unsigned NUM_BOXES    = 9,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned LIFE_W       = 2,
    parameter int unsigned LIFE_INIT    = 3,
    parameter int unsigned WIN_SCORE    = 10,
    parameter int unsigned WARN_TICKS   = 2,
    parameter int unsigned ACTIVE_TICKS = 4,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 super_mode,
    input  logic                 tick,
    input  logic [NUM_BOXES-1:0] box,
    output logic [1:0]           game_state,
    output logic [SCORE_W-1:0]   score,
    output logic [LIFE_W-1:0]    life,
    output logic [NUM_BOXES-1:0] warning_state,
    output logic [NUM_BOXES-1:0] fire_state,
    output logic [NUM_BOXES-1:0] gold_state,
    output logic                 win
);

    localparam int unsigned MAX_TICKS  = (WARN_TICKS > ACTIVE_TICKS) ? WARN_TICKS : ACTIVE_TICKS;
    localparam int unsigned CNT_W      = $clog2(MAX_TICKS + 1);
    localparam int unsigned SUM_W      = SCORE_W + POP_W;
    localparam int unsigned LIFE_CMP_W = LIFE_W + POP_W;

    game_state_t          game_q, game_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIFE_W-1:0]    life_q, life_d;
    logic                 win_q, win_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [NUM_BOXES-1:0] box_q, box_d;
    logic [NUM_BOXES-1:0] rise_q, rise_d;

    logic                 play_active;
    logic                 tick_play;
    logic                 clear;
    logic [7:0]           spawn_idx;
    logic [NUM_BOXES-1:0] spawn_vec;
    logic [NUM_BOXES-1:0] hit_vec;
    logic [NUM_BOXES-1:0] gold_hits;
    logic [NUM_BOXES-1:0] fire_hits;
    logic [NUM_BOXES-1:0] fire_pen;
    logic [CNT_W-1:0]     active_load;
    logic [POP_W-1:0]     gold_cnt;
    logic [POP_W-1:0]     fire_cnt;
    logic [SUM_W-1:0]     score_sum;

    logic [NUM_BOXES-1:0][1:0] cell_st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            game_q  <= GS_IDLE;
            score_q <= '0;
            life_q  <= LIFE_W'(LIFE_INIT);
            win_q   <= 1'b0;
            lfsr_q  <= SEED;
            box_q   <= box;
            rise_q  <= '0;
        end else begin
            game_q  <= game_d;
            score_q <= score_d;
            life_q  <= life_d;
            win_q   <= win_d;
            lfsr_q  <= lfsr_d;
            box_q   <= box_d;
            rise_q  <= rise_d;
        end
    end

    // Rising edges are registered, so a press lands two clocks after the switch moves
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        box_d  = box;
        rise_d = box & ~box_q;
    end

    // Once an end condition is visible the board stops moving until the FSM leaves PLAY
    assign play_active = (game_q == GS_PLAY) && (life_q != '0) &&
                         (score_q != SCORE_W'(WIN_SCORE));
    assign tick_play   = tick && play_active;
    assign hit_vec     = rise_q & {NUM_BOXES{play_active}};
    assign spawn_idx   = lfsr_q[7:0] % 8'(NUM_BOXES);

    always_comb begin
        spawn_vec = '0;
        for (int i = 0; i < int'(NUM_BOXES); i++) begin
            spawn_vec[i] = tick_play && (spawn_idx == 8'(i));
        end
    end

`ifdef DIFFICULTY_RAMP_EN
    logic [SCORE_W-1:0] ramp_step;
    assign ramp_step = score_q >> 2;

    always_comb begin
        if (32'(ramp_step) < ACTIVE_TICKS) begin
            active_load = CNT_W'(ACTIVE_TICKS - 32'(ramp_step));
        end else begin
            active_load = CNT_W'(1);
        end
    end
`else
    assign active_load = CNT_W'(ACTIVE_TICKS);
`endif

    for (genvar g = 0; g < int'(NUM_BOXES); g++) begin : g_cell
        whack_cell #(
            .CNT_W      (CNT_W),
            .WARN_TICKS (WARN_TICKS)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick_play),
            .spawn       (spawn_vec[g]),
            .spawn_kind  (lfsr_q[8]),
            .hit         (hit_vec[g]),
            .active_load (active_load),
            .clear       (clear),
            .state       (cell_st[g]),
            .gold_hit    (gold_hits[g]),
            .fire_hit    (fire_hits[g])
        );
    end

    assign fire_pen  = fire_hits & {NUM_BOXES{~super_mode}};
    assign gold_cnt  = popcount16(16'(gold_hits));
    assign fire_cnt  = popcount16(16'(fire_pen));
    assign score_sum = SUM_W'(score_q) + SUM_W'(gold_cnt);

    // End conditions are judged on registered score/life, one cycle after they update
    always_comb begin
        game_d  = game_q;
        score_d = score_q;
        life_d  = life_q;
        win_d   = win_q;
        clear   = 1'b0;
        case (game_q)
            GS_IDLE: begin
                if (start) begin
                    game_d  = GS_PLAY;
                    score_d = '0;
                    life_d  = LIFE_W'(LIFE_INIT);
                    win_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            GS_PLAY: begin
                if (life_q == '0) begin
                    game_d = GS_OVER;
                    win_d  = 1'b0;
                end else if (score_q == SCORE_W'(WIN_SCORE)) begin
                    game_d = GS_OVER;
                    win_d  = 1'b1;
                end else begin
                    if (score_sum >= SUM_W'(WIN_SCORE)) begin
                        score_d = SCORE_W'(WIN_SCORE);
                    end else begin
                        score_d = SCORE_W'(score_sum);
                    end
                    if (LIFE_CMP_W'(fire_cnt) >= LIFE_CMP_W'(life_q)) begin
                        life_d = '0;
                    end else begin
                        life_d = life_q - LIFE_W'(fire_cnt);
                    end
                end
            end
            GS_OVER: begin
                if (start) begin
                    game_d = GS_IDLE;
                end
            end
            default: begin
                game_d = GS_IDLE;
            end
        endcase
    end

    always_comb begin
        warning_state = '0;
        fire_state    = '0;
        gold_state    = '0;
        for (int i = 0; i < int'(NUM_BOXES); i++) begin
            warning_state[i] = (cell_state_t'(cell_st[i]) == CELL_WARN);
            fire_state[i]    = (cell_state_t'(cell_st[i]) == CELL_FIRE);
            gold_state[i]    = (cell_state_t'(cell_st[i]) == CELL_GOLD);
        end
    end

    assign game_state = game_q;
    assign score      = score_q;
    assign life       = life_q;
    assign win        = win_q;

endmodule

// File: tb/tb_whack_grid_controller.sv
// Directed self-checking bench for whack_grid_controller (default parameters).
module tb_whack_grid_controller;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         super_mode;
    logic         tick;
    logic [N-1:0] box;
    logic [1:0]   game_state;
    logic [3:0]   score;
    logic [1:0]   life;
    logic [N-1:0] warning_state;
    logic [N-1:0] fire_state;
    logic [N-1:0] gold_state;
    logic         win;

    int checks = 0;
    int errors = 0;

    logic [15:0]  lfsr_m;
    logic [N-1:0] gm, fm, snap_w, snap_f, snap_g;

    whack_grid_controller dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .super_mode    (super_mode),
        .tick          (tick),
        .box           (box),
        .game_state    (game_state),
        .score         (score),
        .life          (life),
        .warning_state (warning_state),
        .fire_state    (fire_state),
        .gold_state    (gold_state),
        .win           (win)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left, reset to the seed
    always @(posedge clk) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] m);
        box = '0;
        cyc();
        box = m;
        cyc();
        cyc();
    endtask

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    // kind 0: any gold, 1: any fire, 2: gold and fire lit together
    task automatic find_lit(input int kind, output logic [N-1:0] g, output logic [N-1:0] f);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            if ((kind == 0 && gold_state != '0) || (kind == 1 && fire_state != '0) ||
                (kind == 2 && gold_state != '0 && fire_state != '0)) found = 1'b1;
            else tick_once();
        end
        check_eq("find_lit", 32'(found), 32'd1);
        g = lowest(gold_state);
        f = lowest(fire_state);
    endtask

    task automatic hit_gold();
        logic [N-1:0] g, f;
        find_lit(0, g, f);
        press(g);
    endtask

    task automatic hit_fire();
        logic [N-1:0] g, f;
        find_lit(1, g, f);
        press(f);
    endtask

    task automatic check_first_spawn();
        logic [15:0] e;
        int          idx;
        e   = lfsr_m;
        idx = int'(e[7:0]) % N;
        tick_once();
        check_eq("spawn_warn", 32'(warning_state), e[8] ? (32'd1 << idx) : 32'd0);
        check_eq("spawn_gold", 32'(gold_state), e[8] ? 32'd0 : (32'd1 << idx));
    endtask

    // Follows one fresh WARN spawn through WARN x2 ticks, FIRE x4 ticks, then EMPTY
    task automatic track_warn(input logic hit_end, input int exp_life);
        logic [N-1:0] prev, newb, w;
        logic         found;
        found = 1'b0;
        newb  = '0;
        for (int n = 0; n < 400 && !found; n++) begin
            prev = warning_state;
            tick_once();
            newb = warning_state & ~prev;
            if (newb != '0) found = 1'b1;
        end
        check_eq("find_warn", 32'(found), 32'd1);
        w = lowest(newb);
        tick_once();
        check_eq("warn_t1", 32'(|(warning_state & w)), 32'd1);
        tick_once();
        check_eq("warn_t2_warn", 32'(|(warning_state & w)), 32'd0);
        check_eq("warn_t2_fire", 32'(|(fire_state & w)), 32'd1);
        repeat (3) tick_once();
        check_eq("fire_t5", 32'(|(fire_state & w)), 32'd1);
        if (hit_end) begin
            box = '0;
            cyc();
            box = w;
            cyc();
        end
        tick_once();
        check_eq("fire_t6_empty", 32'(|((fire_state | warning_state | gold_state) & w)), 32'd0);
        check_eq("fire_t6_life", 32'(life), 32'(exp_life));
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b1;
        super_mode = 1'b0;
        tick       = 1'b0;
        box        = '0;
        cyc();
        cyc();
        check_eq("rst_state", 32'(game_state), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_life", 32'(life), 32'd3);
        check_eq("rst_win", 32'(win), 32'd0);
        check_eq("rst_masks", 32'(warning_state | fire_state | gold_state), 32'd0);

        rst   = 1'b1;
        start = 1'b0;
        tick_once();
        check_eq("idle_tick_masks", 32'(warning_state | fire_state | gold_state), 32'd0);
        check_eq("idle_state", 32'(game_state), 32'd0);

        // Game 1: gold latency, super fire, expiry timing, loss
        pulse_start();
        check_eq("g1_play", 32'(game_state), 32'd1);
        check_eq("g1_life", 32'(life), 32'd3);
        check_eq("g1_score", 32'(score), 32'd0);
        check_first_spawn();

        find_lit(0, gm, fm);
        box = '0;
        cyc();
        box = gm;
        cyc();
        check_eq("gold_lat1_score", 32'(score), 32'd0);
        cyc();
        check_eq("gold_lat2_score", 32'(score), 32'd1);
        check_eq("gold_cleared", 32'(|(gold_state & gm)), 32'd0);
        check_eq("gold_life", 32'(life), 32'd3);

        super_mode = 1'b1;
        find_lit(1, gm, fm);
        press(fm);
        check_eq("super_fire_cleared", 32'(|(fire_state & fm)), 32'd0);
        check_eq("super_fire_life", 32'(life), 32'd3);
        super_mode = 1'b0;

        track_warn(1'b0, 3);
        track_warn(1'b1, 2);

        hit_fire();
        check_eq("fire_life1", 32'(life), 32'd1);
        hit_fire();
        check_eq("fire_life0", 32'(life), 32'd0);
        check_eq("fire_still_play", 32'(game_state), 32'd1);
        cyc();
        check_eq("loss_over", 32'(game_state), 32'd2);
        check_eq("loss_win", 32'(win), 32'd0);

        snap_w = warning_state;
        snap_f = fire_state;
        snap_g = gold_state;
        tick_once();
        press('1);
        check_eq("over_frozen_warn", 32'(warning_state), 32'(snap_w));
        check_eq("over_frozen_fire", 32'(fire_state), 32'(snap_f));
        check_eq("over_frozen_gold", 32'(gold_state), 32'(snap_g));
        check_eq("over_score", 32'(score), 32'd1);
        check_eq("over_life", 32'(life), 32'd0);
        check_eq("over_hold", 32'(game_state), 32'd2);

        pulse_start();
        check_eq("over_to_idle", 32'(game_state), 32'd0);
        pulse_start();
        check_eq("g2_play", 32'(game_state), 32'd1);
        check_eq("g2_score", 32'(score), 32'd0);
        check_eq("g2_life", 32'(life), 32'd3);
        check_eq("g2_masks", 32'(warning_state | fire_state | gold_state), 32'd0);
        check_first_spawn();

        // Game 2: win by score
        for (int k = 1; k <= 10; k++) begin
            hit_gold();
            check_eq("g2_score_step", 32'(score), 32'(k));
        end
        check_eq("g2_pre_over", 32'(game_state), 32'd1);
        cyc();
        check_eq("win_over", 32'(game_state), 32'd2);
        check_eq("win_flag", 32'(win), 32'd1);
        check_eq("win_life", 32'(life), 32'd3);

        // Game 3: simultaneous final gold and final fire -> loss wins
        pulse_start();
        pulse_start();
        check_eq("g3_play", 32'(game_state), 32'd1);
        check_eq("g3_win_clear", 32'(win), 32'd0);
        repeat (9) hit_gold();
        check_eq("g3_score9", 32'(score), 32'd9);
        hit_fire();
        hit_fire();
        check_eq("g3_life1", 32'(life), 32'd1);
        find_lit(2, gm, fm);
        press(gm | fm);
        check_eq("both_score", 32'(score), 32'd10);
        check_eq("both_life", 32'(life), 32'd0);
        cyc();
        check_eq("both_over", 32'(game_state), 32'd2);
        check_eq("both_win", 32'(win), 32'd0);

        pulse_start();
        check_eq("g3_idle", 32'(game_state), 32'd0);
        pulse_start();
        check_eq("g4_play", 32'(game_state), 32'd1);
        check_eq("g4_score", 32'(score), 32'd0);
        check_eq("g4_life", 32'(life), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
